mem_port_arbiter: RTL

// Shares one single-port unified memory between the fetch stage (instruction reads) and the MEM stage (loads/stores).

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter_bus_watchdog.sv | 29 ++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state/source encodings and width helper for the memory port arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   typedef enum logic {
      SRC_IF  = 1'b0,
      SRC_MEM = 1'b1
   } arb_src_t;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-bus signals of the arbiter
// slave is the arbiter itself; master is whatever drives the requests and the memory response.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  i_if_req;
   logic [ADDR_W-1:0]     i_if_addr;
   logic [DATA_W-1:0]     o_if_rdata;
   logic                  o_if_valid;
   logic                  o_if_stall;

   logic                  i_mem_req;
   logic                  i_mem_we;
   logic [ADDR_W-1:0]     i_mem_addr;
   logic [DATA_W-1:0]     i_mem_wdata;
   logic [DATA_W/8-1:0]   i_mem_wstrb;
   logic [DATA_W-1:0]     o_mem_rdata;
   logic                  o_mem_valid;
   logic                  o_mem_stall;

   logic                  o_bus_req;
   logic                  o_bus_we;
   logic [ADDR_W-1:0]     o_bus_addr;
   logic [DATA_W-1:0]     o_bus_wdata;
   logic [DATA_W/8-1:0]   o_bus_wstrb;
   logic                  i_bus_ready;
   logic [DATA_W-1:0]     i_bus_rdata;
   logic                  o_bus_err;

   modport slave (
      input  i_if_req, i_if_addr,
      output o_if_rdata, o_if_valid, o_if_stall,
      input  i_mem_req, i_mem_we, i_mem_addr, i_mem_wdata, i_mem_wstrb,
      output o_mem_rdata, o_mem_valid, o_mem_stall,
      output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wstrb, o_bus_err,
      input  i_bus_ready, i_bus_rdata
   );

   modport master (
      output i_if_req, i_if_addr,
      input  o_if_rdata, o_if_valid, o_if_stall,
      output i_mem_req, i_mem_we, i_mem_addr, i_mem_wdata, i_mem_wstrb,
      input  o_mem_rdata, o_mem_valid, o_mem_stall,
      input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wstrb, o_bus_err,
      output i_bus_ready, i_bus_rdata
   );
endinterface

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// rtl/mem_port_arbiter_bus_watchdog.sv - bus access timeout counter with clear/enable/expire
// Counts enabled cycles since the last clear; expire flags the TIMEOUT-th enabled cycle.
module mem_port_arbiter_bus_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);
   localparam int WW = cnt_w(TIMEOUT - 1);

   logic [WW-1:0] r_cnt;
   logic          w_at_limit;

   assign w_at_limit = (r_cnt == WW'(TIMEOUT - 1));
   assign o_expire   = i_enable & w_at_limit;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !w_at_limit) begin
         r_cnt <= r_cnt + WW'(1);
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data, data first with fetch starvation bound
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_port_arbiter_if.slave    bus
);
   localparam int SW = cnt_w(STARVE_MAX);

   arb_state_t            r_state, w_state_nxt;
   arb_src_t              r_src;
   logic [SW-1:0]         r_starve_cnt;
   logic                  r_bus_req, r_bus_we, r_bus_err;
   logic [ADDR_W-1:0]     r_bus_addr;
   logic [DATA_W-1:0]     r_bus_wdata;
   logic [DATA_W/8-1:0]   r_bus_wstrb;
   logic [DATA_W-1:0]     r_if_rdata, r_mem_rdata;
   logic                  w_grant_i, w_grant_d, w_done, w_abort, w_expire, w_busy;
   logic                  w_if_valid, w_mem_valid;

   assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);

   mem_port_arbiter_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_grant_i | w_grant_d),
      .i_enable (w_busy),
      .o_expire (w_expire)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.i_mem_req && (!bus.i_if_req || r_starve_cnt < SW'(STARVE_MAX))) begin
               w_grant_d   = 1'b1;
               w_state_nxt = BUSY_D;
            end else if (bus.i_if_req) begin
               w_grant_i   = 1'b1;
               w_state_nxt = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            // A ready arriving on the timeout cycle still completes normally.
            if (bus.i_bus_ready) begin
               w_done      = 1'b1;
               w_state_nxt = RESP;
            end else if (w_expire) begin
               w_abort     = 1'b1;
               w_state_nxt = RESP;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_src        <= SRC_IF;
         r_starve_cnt <= '0;
         r_bus_req    <= 1'b0;
         r_bus_we     <= 1'b0;
         r_bus_err    <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_wdata  <= '0;
         r_bus_wstrb  <= '0;
         r_if_rdata   <= '0;
         r_mem_rdata  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_i || w_grant_d) begin
            r_bus_req   <= 1'b1;
            r_src       <= w_grant_d ? SRC_MEM : SRC_IF;
            r_bus_we    <= w_grant_d & bus.i_mem_we;
            r_bus_addr  <= w_grant_d ? bus.i_mem_addr : bus.i_if_addr;
            r_bus_wdata <= w_grant_d ? bus.i_mem_wdata : '0;
            r_bus_wstrb <= w_grant_d ? bus.i_mem_wstrb : '0;
         end
         // Data grants only count against fetch while fetch is actually waiting.
         if (w_grant_i) begin
            r_starve_cnt <= '0;
         end else if (w_grant_d) begin
            r_starve_cnt <= bus.i_if_req ? r_starve_cnt + SW'(1) : '0;
         end
         if (w_done || w_abort) begin
            r_bus_req <= 1'b0;
            if (w_abort) begin
               r_bus_err <= 1'b1;
            end
            if (r_src == SRC_MEM) begin
               r_mem_rdata <= (w_done && !r_bus_we) ? bus.i_bus_rdata : '0;
            end else begin
               r_if_rdata  <= w_done ? bus.i_bus_rdata : '0;
            end
         end
      end
   end

   assign w_if_valid  = (r_state == RESP) && (r_src == SRC_IF);
   assign w_mem_valid = (r_state == RESP) && (r_src == SRC_MEM);

   assign bus.o_if_valid  = w_if_valid;
   assign bus.o_mem_valid = w_mem_valid;
   assign bus.o_if_stall  = bus.i_if_req & ~w_if_valid;
   assign bus.o_mem_stall = bus.i_mem_req & ~w_mem_valid;
   assign bus.o_if_rdata  = r_if_rdata;
   assign bus.o_mem_rdata = r_mem_rdata;
   assign bus.o_bus_req   = r_bus_req;
   assign bus.o_bus_we    = r_bus_we;
   assign bus.o_bus_addr  = r_bus_addr;
   assign bus.o_bus_wdata = r_bus_wdata;
   assign bus.o_bus_wstrb = r_bus_wstrb;
   assign bus.o_bus_err   = r_bus_err;
endmodule
